sine_phase_gen: RTL and testbench
=================================

Name: sine_phase_gen

Overview:
- Phase-accumulator address generator that sits directly upstream of the sine lookup ROM (256 x 8, synchronous read).
- Produces two ROM addresses per cycle:
  - addr1: the primary phase.
  - addr2: addr1 plus a runtime phase offset, for the dual-channel / phase-shifted output.
- Frequency is set by an accumulator increment loaded through a valid/ready handshake. A new increment takes effect only at a phase wrap, so frequency changes are glitch-free.

Parameters:
- ACC_WIDTH, 16, phase accumulator width in bits.
- ADDRESS_WIDTH, 8, ROM address width. Addresses are acc[ACC_WIDTH-1 -: ADDRESS_WIDTH].
- DEFAULT_INCR, 16'h0100, increment active after reset (one ROM address per cycle).
- CNT_WIDTH, 16, width of the completed-period counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance phase when 1; hold phase when 0.
- incr_in  input  ACC_WIDTH  new phase increment.
- incr_valid  input  1  incr_in is valid.
- incr_ready  output  1  block can accept a new increment.
- offset  input  ADDRESS_WIDTH  phase offset for addr2, in ROM address units.
- addr1  output  ADDRESS_WIDTH  primary ROM address (registered).
- addr2  output  ADDRESS_WIDTH  offset ROM address (registered).
- wrap  output  1  one-cycle pulse when the accumulator wraps.
- period_cnt  output  CNT_WIDTH  number of completed phase periods.

Behaviour:
- Interface: one clock domain, clk. Reset is synchronous and active-high on rst, sampled on posedge clk. rst has priority over all other inputs.
- Reset state:
  - acc=0, incr_active=DEFAULT_INCR, pending_valid=0.
  - incr_ready=1, addr1=0, addr2=0, wrap=0, period_cnt=0.
  - Reset mid-operation discards any pending increment and any pending wrap pulse.
- Step computation: sum = {1'b0,acc} + incr_active, ACC_WIDTH+1 bits. carry = sum[ACC_WIDTH]; next_acc = sum[ACC_WIDTH-1:0]. Arithmetic is modulo 2^ACC_WIDTH.
- When en=1, each edge:
  - acc<=next_acc.
  - addr1<=next_acc[top ADDRESS_WIDTH bits].
  - addr2<=(those bits + offset) mod 2^ADDRESS_WIDTH.
  - wrap<=carry.
  - period_cnt<=period_cnt+carry. period_cnt wraps modulo 2^CNT_WIDTH; it does not saturate.
- When en=0, each edge:
  - acc, addr1, wrap<=0, and period_cnt hold.
  - addr2<=(addr1+offset) mod 2^ADDRESS_WIDTH, so an offset change is visible one cycle later even while paused.
- Latency:
  - addr outputs reflect the accumulator state produced at the same edge.
  - ROM data follows one further cycle later, since the ROM read is synchronous.
- Increment handshake:
  - Transfer occurs on an edge where incr_valid=1 and incr_ready=1: pending<=incr_in, pending_valid<=1, incr_ready<=0.
  - incr_ready is registered and equals !pending_valid.
  - Only one pending slot exists. incr_valid while incr_ready=0 is ignored; the source must hold incr_valid until the transfer.
- Apply rule: pending is copied to incr_active (pending_valid<=0, incr_ready<=1 at the same edge) at either of:
  - (a) an edge with en=1 and carry=1. The new increment is used from the following step; the step producing the carry still uses the old increment.
  - (b) an edge with en=0 and acc==0 (idle load).
- Capture and apply cannot occur at the same edge, because incr_ready=0 whenever pending_valid=1.
- Increment of 0 is legal: the phase freezes, carry never occurs, and a later pending increment can only be applied via rule (b).
- Increment of 2^ACC_WIDTH-1 is legal: carry occurs on every step except from acc=0.

Test Plan:
- Reset then en=1 for 300 cycles with default increment -> addr1 counts 1,2,...,255,0,1...; wrap pulses on the cycle addr1 goes 255->0 (cycle 256); period_cnt=1 after cycle 256.
- en=1, offset=8'h40 -> addr2 = addr1+64 mod 256 every cycle (addr1=200 gives addr2=8); change offset to 8'h80 with en=0 -> addr2 updates after one edge while addr1 holds.
- At addr1=10, handshake incr_in=16'h0200 -> incr_ready falls next cycle; addr1 keeps stepping by 1 until the wrap, then steps 2,4,6...; incr_ready returns to 1 at the wrap edge.
- Second incr_valid while incr_ready=0 with incr_in=16'h0400 -> ignored; only 16'h0200 is ever applied.
- Reset, en=0, load incr_in=16'h0080 -> applied immediately by idle-load rule; en=1 -> addr1 advances by 1 every 2 cycles.
- Assert rst with a pending increment and addr1=0x7F -> next cycle: all outputs at reset values, incr_ready=1, increment back to 16'h0100.

Source files
------------

// File: rtl/sine_phase_gen.sv
// -----------------------------------------------------------------------------
// sine_phase_gen
//
// Phase-accumulator address generator feeding a 256 x 8 synchronous sine ROM.
// Produces a primary ROM address (addr1) and a phase-shifted address (addr2 =
// addr1 + offset) every cycle. The frequency word is loaded through a
// valid/ready handshake into a single pending slot. It only becomes active at a
// phase wrap, or immediately while paused at phase zero, so the output
// waveform never glitches mid-period.
//
// Ports
//   clk         system clock, all state on posedge
//   rst         synchronous active-high reset, highest priority
//   en          1: advance phase, 0: hold phase
//   incr_in     new phase increment
//   incr_valid  incr_in is valid
//   incr_ready  pending slot is free (registered)
//   offset      phase offset for addr2, in ROM address units
//   addr1       primary ROM address (registered)
//   addr2       offset ROM address (registered)
//   wrap        one-cycle pulse when the accumulator carries out
//   period_cnt  completed phase periods, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module sine_phase_gen #(
    parameter int                   ACC_WIDTH     = 16,
    parameter int                   ADDRESS_WIDTH = 8,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INCR  = 16'h0100,
    parameter int                   CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr_in,
    input  logic                     incr_valid,
    output logic                     incr_ready,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic                     wrap,
    output logic [CNT_WIDTH-1:0]     period_cnt
);

    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [ACC_WIDTH-1:0]     incr_active_q, incr_active_d;
    logic [ACC_WIDTH-1:0]     pending_q, pending_d;
    logic                     pending_valid_q, pending_valid_d;
    logic                     incr_ready_q, incr_ready_d;
    logic [ADDRESS_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
    logic                     wrap_q, wrap_d;
    logic [CNT_WIDTH-1:0]     period_cnt_q, period_cnt_d;

    // One extra bit on the sum exposes the carry that marks a phase wrap.
    logic [ACC_WIDTH:0]       sum;
    logic                     carry;
    logic [ACC_WIDTH-1:0]     next_acc;
    logic                     do_capture;
    logic                     do_apply;

    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, incr_active_q};
        carry    = sum[ACC_WIDTH];
        next_acc = sum[ACC_WIDTH-1:0];

        acc_d        = acc_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        wrap_d       = 1'b0;
        period_cnt_d = period_cnt_q;

        if (en) begin
            acc_d        = next_acc;
            addr1_d      = next_acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
            addr2_d      = next_acc[ACC_WIDTH-1 -: ADDRESS_WIDTH] + offset;
            wrap_d       = carry;
            period_cnt_d = period_cnt_q + CNT_WIDTH'(carry);
        end else begin
            // Phase is frozen, but addr2 still tracks offset so a phase-shift
            // change while paused shows up one edge later.
            addr2_d = addr1_q + offset;
        end

        // Capture and apply are mutually exclusive: capture needs an empty
        // slot, apply needs a full one.
        do_capture = incr_valid && incr_ready_q;
        do_apply   = pending_valid_q &&
                     ((en && carry) || (!en && (acc_q == '0)));

        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        incr_active_d   = incr_active_q;

        if (do_capture) begin
            pending_d       = incr_in;
            pending_valid_d = 1'b1;
        end
        // On a carry the step that wrapped already used the old increment;
        // the new one drives the next step onward.
        if (do_apply) begin
            incr_active_d   = pending_q;
            pending_valid_d = 1'b0;
        end

        incr_ready_d = !pending_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q           <= '0;
            incr_active_q   <= DEFAULT_INCR;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            incr_ready_q    <= 1'b1;
            addr1_q         <= '0;
            addr2_q         <= '0;
            wrap_q          <= 1'b0;
            period_cnt_q    <= '0;
        end else begin
            acc_q           <= acc_d;
            incr_active_q   <= incr_active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            incr_ready_q    <= incr_ready_d;
            addr1_q         <= addr1_d;
            addr2_q         <= addr2_d;
            wrap_q          <= wrap_d;
            period_cnt_q    <= period_cnt_d;
        end
    end

    assign incr_ready = incr_ready_q;
    assign addr1      = addr1_q;
    assign addr2      = addr2_q;
    assign wrap       = wrap_q;
    assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed bench for sine_phase_gen. A phase/period model using plain integer
// arithmetic and a one-deep queue for the pending increment predicts every
// output; a compare process checks the DUT on each falling edge, and literal
// checks in the stimulus pin the model to hand-computed values.
module tb_sine_phase_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] incr_in;
    logic        incr_valid;
    logic        incr_ready;
    logic [7:0]  offset;
    logic [7:0]  addr1;
    logic [7:0]  addr2;
    logic        wrap;
    logic [15:0] period_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sine_phase_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .incr_in    (incr_in),
        .incr_valid (incr_valid),
        .incr_ready (incr_ready),
        .offset     (offset),
        .addr1      (addr1),
        .addr2      (addr2),
        .wrap       (wrap),
        .period_cnt (period_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_phase;      // phase in 0 .. 65535
    int  m_step;       // active increment
    int  m_pend[$];    // pending increment slot (0 or 1 entries)
    int  m_a1, m_a2, m_wrap, m_cnt, m_ready;
    bit  chk_on = 1'b0;

    always @(posedge clk) begin
        int  s;
        bit  c;
        bit  take;
        int  old_phase;
        if (rst) begin
            m_phase = 0; m_step = 256; m_pend.delete();
            m_a1 = 0; m_a2 = 0; m_wrap = 0; m_cnt = 0; m_ready = 1;
            chk_on = 1'b1;
        end else if (chk_on) begin
            take      = incr_valid && (m_ready == 1);
            old_phase = m_phase;
            c         = 1'b0;
            if (en) begin
                s       = m_phase + m_step;
                c       = (s >= 65536);
                m_phase = s % 65536;
                m_a1    = m_phase / 256;
                m_a2    = (m_a1 + int'(offset)) % 256;
                m_wrap  = c;
                m_cnt   = (m_cnt + c) % 65536;
            end else begin
                m_a2   = (m_a1 + int'(offset)) % 256;
                m_wrap = 0;
            end
            if (m_pend.size() != 0 && ((en && c) || (!en && old_phase == 0)))
                m_step = m_pend.pop_front();
            if (take)
                m_pend.push_back(int'(incr_in));
            m_ready = (m_pend.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("addr1",      int'(addr1),      m_a1);
            chk("addr2",      int'(addr2),      m_a2);
            chk("wrap",       int'(wrap),       m_wrap);
            chk("period_cnt", int'(period_cnt), m_cnt);
            chk("incr_ready", int'(incr_ready), m_ready);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; incr_in = '0; incr_valid = 1'b0; offset = '0;
        tick(2);
        chk("rst_addr1", int'(addr1), 0);
        chk("rst_addr2", int'(addr2), 0);
        chk("rst_wrap",  int'(wrap), 0);
        chk("rst_cnt",   int'(period_cnt), 0);
        chk("rst_ready", int'(incr_ready), 1);

        // Default increment: one address per cycle, wrap at cycle 256.
        rst = 1'b0; en = 1'b1;
        tick(1);
        chk("def_a1_c1", int'(addr1), 1);
        tick(254);
        chk("def_a1_c255", int'(addr1), 255);
        chk("def_nowrap_c255", int'(wrap), 0);
        tick(1);
        chk("def_a1_c256", int'(addr1), 0);
        chk("def_wrap_c256", int'(wrap), 1);
        chk("def_cnt_c256", int'(period_cnt), 1);
        tick(1);
        chk("def_wrap_c257", int'(wrap), 0);
        tick(43);
        chk("def_a1_c300", int'(addr1), 44);

        // Offset tracking, then offset change while paused.
        offset = 8'h40;
        tick(1);
        chk("off_a2_45", int'(addr2), 109);
        tick(155);
        chk("off_a1_200", int'(addr1), 200);
        chk("off_a2_200", int'(addr2), 8);
        en = 1'b0; offset = 8'h80;
        tick(1);
        chk("pause_a1", int'(addr1), 200);
        chk("pause_a2", int'(addr2), 72);
        tick(1);
        chk("pause_a1_hold", int'(addr1), 200);

        // Handshake at addr1=10, applied at the next wrap.
        en = 1'b1;
        tick(66);
        chk("hs_a1_10", int'(addr1), 10);
        chk("hs_cnt_2", int'(period_cnt), 2);
        incr_valid = 1'b1; incr_in = 16'h0200;
        tick(1);
        chk("hs_ready_low", int'(incr_ready), 0);
        chk("hs_a1_11", int'(addr1), 11);
        // Second request while the slot is full must be ignored.
        incr_in = 16'h0400;
        tick(3);
        incr_valid = 1'b0;
        chk("hs_a1_14", int'(addr1), 14);
        tick(241);
        chk("hs_a1_255", int'(addr1), 255);
        chk("hs_ready_still_low", int'(incr_ready), 0);
        tick(1);
        chk("hs_wrap", int'(wrap), 1);
        chk("hs_ready_back", int'(incr_ready), 1);
        chk("hs_cnt_3", int'(period_cnt), 3);
        tick(1); chk("hs_step2_a", int'(addr1), 2);
        tick(1); chk("hs_step2_b", int'(addr1), 4);
        tick(1); chk("hs_step2_c", int'(addr1), 6);
        tick(127);
        chk("hs_still_step2", int'(addr1), 4);
        chk("hs_cnt_4", int'(period_cnt), 4);

        // Idle load while paused at phase zero.
        rst = 1'b1;
        tick(1);
        rst = 1'b0; en = 1'b0; incr_valid = 1'b1; incr_in = 16'h0080;
        tick(1);
        chk("idle_captured", int'(incr_ready), 0);
        incr_valid = 1'b0;
        tick(1);
        chk("idle_applied", int'(incr_ready), 1);
        en = 1'b1;
        tick(2);
        chk("half_a1_1", int'(addr1), 1);
        tick(2);
        chk("half_a1_2", int'(addr1), 2);

        // Reset with a pending increment at addr1=0x7F.
        tick(250);
        chk("pre_rst_a1", int'(addr1), 8'h7F);
        incr_valid = 1'b1; incr_in = 16'h0400;
        tick(1);
        incr_valid = 1'b0;
        chk("pre_rst_ready", int'(incr_ready), 0);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_a1", int'(addr1), 0);
        chk("mid_rst_a2", int'(addr2), 0);
        chk("mid_rst_wrap", int'(wrap), 0);
        chk("mid_rst_cnt", int'(period_cnt), 0);
        chk("mid_rst_ready", int'(incr_ready), 1);
        rst = 1'b0;
        tick(1);
        chk("post_rst_a1", int'(addr1), 1);
        chk("post_rst_a2", int'(addr2), 8'h81);
        tick(1);
        chk("post_rst_a1_b", int'(addr1), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
